// File: rtl/pulse_handshake_tx.sv
// Source side of a toggle-based pulse handshake: buffers event pulses in a counter
// and launches them one at a time, waiting for the synchronized acknowledge toggle.
module pulse_handshake_tx #(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             ack_tgl,
    input  logic             ovf_clr,
    output logic             req_tgl,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             overflow
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   launch;
    logic                   ack_match;
    logic [CNT_W:0]         cnt_sum;
    logic                   drop;
    logic [CNT_W-1:0]       pend_next;

    // Plain flop chain: no logic between stages so metastability can settle.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ack_sync <= '0;
        else     ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_tgl};
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        ack_match  = 1'b0;
        case (state)
            IDLE: begin
                if (pend_cnt != '0 || pulse_in) begin
                    launch     = 1'b1;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_s == req_tgl) begin
                    ack_match  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Carry out of the widened sum only happens at full count with a pulse and no launch.
    always_comb begin
        cnt_sum   = {1'b0, pend_cnt} + {{CNT_W{1'b0}}, pulse_in} - {{CNT_W{1'b0}}, launch};
        drop      = cnt_sum[CNT_W];
        pend_next = drop ? pend_cnt : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            req_tgl  <= 1'b0;
            pend_cnt <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            req_tgl  <= req_tgl ^ launch;
            pend_cnt <= pend_next;
            done     <= ack_match;
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign busy = (state == WAIT_ACK);

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Directed bench for pulse_handshake_tx: loopback or forced acknowledge, with
// monitors counting req_tgl toggles, done pulses and peak pend_cnt.
module tb_pulse_handshake_tx;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             pulse_in;
    logic             ack_tgl;
    logic             ovf_clr;
    logic             req_tgl;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pend_cnt;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int tgl_cnt  = 0;
    int done_cnt = 0;
    int pend_max = 0;
    logic req_prev = 1'b0;

    logic       loopback;
    logic       ack_force;
    logic [2:0] dly;

    pulse_handshake_tx #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .ack_tgl  (ack_tgl),
        .ovf_clr  (ovf_clr),
        .req_tgl  (req_tgl),
        .busy     (busy),
        .done     (done),
        .pend_cnt (pend_cnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Destination model: echoes req_tgl after three cycles, reset with the system.
    always @(posedge clk or posedge rst) begin
        if (rst) dly <= '0;
        else     dly <= {dly[1:0], req_tgl};
    end

    assign ack_tgl = loopback ? dly[2] : ack_force;

    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (req_tgl != req_prev) tgl_cnt++;
            if (int'(pend_cnt) > pend_max) pend_max = int'(pend_cnt);
        end
        req_prev = req_tgl;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        tgl_cnt  = 0;
        done_cnt = 0;
        pend_max = 0;
    endtask

    task automatic do_reset();
        pulse_in = 1'b0;
        ovf_clr  = 1'b0;
        rst      = 1'b1;
        step(2);
        rst      = 1'b0;
        clear_mon();
    endtask

    task automatic pulse(input int n);
        pulse_in = 1'b1;
        step(n);
        pulse_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 50) begin
            step();
            k++;
        end
        if (busy) check({tag, "_timeout"}, 32'(busy), 32'd0);
    endtask

    initial begin
        loopback  = 1'b1;
        ack_force = 1'b0;
        pulse_in  = 1'b0;
        ovf_clr   = 1'b0;
        rst       = 1'b1;
        step(2);

        // Reset values
        check("rst_req_tgl",  32'(req_tgl),  32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_pend_cnt", 32'(pend_cnt), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Single event, launched on the first edge after reset release
        rst = 1'b0;
        clear_mon();
        pulse(1);
        check("single_req_tgl", 32'(req_tgl),  32'd1);
        check("single_busy",    32'(busy),     32'd1);
        check("single_pend",    32'(pend_cnt), 32'd0);
        step(20);
        check("single_done_cnt", 32'(done_cnt), 32'd1);
        check("single_tgl_cnt",  32'(tgl_cnt),  32'd1);
        check("single_pend_max", 32'(pend_max), 32'd0);
        check("single_idle",     32'(busy),     32'd0);

        // Burst of five
        do_reset();
        pulse(5);
        check("burst_pend_after", 32'(pend_cnt), 32'd4);
        step(60);
        check("burst_pend_max", 32'(pend_max), 32'd4);
        check("burst_tgl_cnt",  32'(tgl_cnt),  32'd5);
        check("burst_done_cnt", 32'(done_cnt), 32'd5);
        check("burst_req_tgl",  32'(req_tgl),  32'd1);
        check("burst_pend_end", 32'(pend_cnt), 32'd0);

        // Pulse coinciding with a launch at pend_cnt = 3
        do_reset();
        loopback  = 1'b0;
        ack_force = 1'b0;
        pulse(4);
        check("simul_pend_pre", 32'(pend_cnt), 32'd3);
        ack_force = 1'b1;
        wait_idle("simul");
        pulse(1);
        check("simul_pend",    32'(pend_cnt), 32'd3);
        check("simul_req_tgl", 32'(req_tgl),  32'd0);
        check("simul_busy",    32'(busy),     32'd1);

        // Overflow with acknowledge stalled
        do_reset();
        loopback  = 1'b0;
        ack_force = 1'b0;
        pulse(16);
        check("ovf_pend_full", 32'(pend_cnt), 32'd15);
        check("ovf_not_yet",   32'(overflow), 32'd0);
        pulse(1);
        check("ovf_pend_hold", 32'(pend_cnt), 32'd15);
        check("ovf_set",       32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        pulse(1);
        check("ovf_set_wins", 32'(overflow), 32'd1);
        step(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        check("ovf_busy",    32'(busy),     32'd1);
        clear_mon();
        loopback = 1'b1;
        step(200);
        check("ovf_tgl_cnt",  32'(tgl_cnt),  32'd15);
        check("ovf_done_cnt", 32'(done_cnt), 32'd16);
        check("ovf_pend_end", 32'(pend_cnt), 32'd0);
        check("ovf_stays_0",  32'(overflow), 32'd0);

        // Asynchronous reset while busy with two pending
        do_reset();
        loopback  = 1'b0;
        ack_force = 1'b0;
        pulse(3);
        check("arst_pend_pre", 32'(pend_cnt), 32'd2);
        check("arst_busy_pre", 32'(busy),     32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_req_tgl",  32'(req_tgl),  32'd0);
        check("arst_busy",     32'(busy),     32'd0);
        check("arst_pend",     32'(pend_cnt), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_done",     32'(done),     32'd0);
        step(2);
        rst      = 1'b0;
        loopback = 1'b1;
        clear_mon();
        step(30);
        check("arst_no_tgl",  32'(tgl_cnt),  32'd0);
        check("arst_no_done", 32'(done_cnt), 32'd0);

        // Spurious acknowledge toggle while idle
        do_reset();
        loopback  = 1'b0;
        ack_force = 1'b1;
        step(10);
        check("spur_done_cnt", 32'(done_cnt), 32'd0);
        check("spur_req_tgl",  32'(req_tgl),  32'd0);
        check("spur_busy",     32'(busy),     32'd0);
        ack_force = 1'b0;
        step(10);
        check("spur_done_cnt2", 32'(done_cnt), 32'd0);
        check("spur_tgl_cnt",   32'(tgl_cnt),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_handshake_tx.md
PULSE_HANDSHAKE_TX -- requirements
Module: pulse_handshake_tx

Interface
REQ-001 Parameter CNT_W, default 4: width of the pending-pulse counter; holds at most 2^CNT_W-1 pulses.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: number of flops in the ack_tgl synchronizer.
REQ-003 clk  input  1  single clock of the source domain; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-high.
REQ-005 pulse_in  input  1  one-cycle event request; each high cycle counts as one event.
REQ-006 ack_tgl  input  1  acknowledge toggle from the destination domain; asynchronous to clk.
REQ-007 ovf_clr  input  1  synchronous clear of the overflow flag.
REQ-008 req_tgl  output  1  request toggle level driven to the destination; registered.
REQ-009 busy  output  1  high while a transfer awaits acknowledge.
REQ-010 done  output  1  one-cycle pulse when an acknowledge completes a transfer.
REQ-011 pend_cnt  output  CNT_W  events accepted but not yet launched.
REQ-012 overflow  output  1  sticky flag: an event was dropped.

Function
REQ-013 ack_tgl shall pass through SYNC_STAGES flops clocked by clk; ack_s is the last stage; no logic between stages.
REQ-014 FSM states: IDLE, WAIT_ACK; busy = (state == WAIT_ACK).
REQ-015 launch = (state == IDLE) && (pend_cnt != 0 || pulse_in).
REQ-016 On launch: req_tgl inverts at the same edge; state -> WAIT_ACK.
REQ-017 In WAIT_ACK: when ack_s == req_tgl, state -> IDLE and done = 1 for exactly that next cycle; otherwise remain.
REQ-018 At least one IDLE cycle between transfers; back-to-back launch spacing is therefore >= SYNC_STAGES+2 cycles, plus destination latency.
REQ-019 Counter: pend_cnt_next = pend_cnt + pulse_in - launch, computed in CNT_W+1 bits.
REQ-020 pulse_in with pend_cnt == 0 in IDLE: launches directly; pend_cnt stays 0.
REQ-021 Simultaneous pulse_in and launch with pend_cnt > 0: pend_cnt unchanged.
REQ-022 pulse_in with pend_cnt == 2^CNT_W-1 and no launch: pend_cnt holds; event dropped; overflow set next edge.
REQ-023 overflow stays set until ovf_clr = 1; when ovf_clr and a new drop occur in the same cycle, set wins.
REQ-024 req_tgl changes only on launch; no glitch; never changes in WAIT_ACK.
REQ-025 pulse_in during WAIT_ACK is counted per REQ-019; events are never merged.
REQ-026 ack_s change while IDLE (spurious): ignored; no done, no state change.

Reset
REQ-027 While rst = 1: state = IDLE, req_tgl = 0, pend_cnt = 0, overflow = 0, done = 0, busy = 0, all synchronizer flops = 0.
REQ-028 Reset mid-transfer discards the in-flight event and all pending events; the destination is reset in the same system reset so its ack level returns to 0.
REQ-029 First launch is allowed on the first clk edge after rst deasserts.

Verification
REQ-030 Single event: reset, pulse_in for 1 cycle, loopback ack_tgl = req_tgl through 3-cycle delay -> req_tgl 0->1 next edge, busy 1, done pulses once at ack_s match, pend_cnt stays 0.
REQ-031 Burst: 5 consecutive pulse_in cycles with ack loopback -> pend_cnt peaks at 4, exactly 5 req_tgl toggles, 5 done pulses, final req_tgl = 1.
REQ-032 Overflow: CNT_W = 4, ack_tgl held at 0 after first launch, 17 pulses -> pend_cnt = 15, overflow = 1; ovf_clr -> overflow 0; 15 toggles after ack released.
REQ-033 Simultaneous pulse and launch at pend_cnt = 3 -> pend_cnt remains 3 on that edge.
REQ-034 Reset while busy with pend_cnt = 2 -> all outputs to reset values immediately (asynchronously), no further toggles after release without new pulse_in.
REQ-035 Spurious ack: toggle ack_tgl while IDLE -> no done, req_tgl unchanged, state IDLE.
